// File: rtl/cory_join_if.sv
// cory_join_if: per-lane input handshakes plus the joined output port of cory_join
interface cory_join_if #(parameter int N = 4, W = 8, CW = 8);
  logic [N-1:0] i_ax_v, o_ax_r, o_pend;
  logic [N*W-1:0] i_ax_d, o_z_d;
  logic o_z_v, i_z_r;
  logic [CW-1:0] o_z_skew;
  modport slave(input i_ax_v, i_ax_d, i_z_r, output o_ax_r, o_z_v, o_z_d, o_z_skew, o_pend);
  modport master(output i_ax_v, i_ax_d, i_z_r, input o_ax_r, o_z_v, o_z_d, o_z_skew, o_pend);
endinterface

// File: rtl/cory_join.sv
// cory_join: gathers one beat per lane into holding slots and emits one concatenated beat with lane skew
module cory_join #(parameter int N = 4, W = 8, CW = 8) (
  input logic clk,
  input logic reset_n,
  cory_join_if.slave bus
);
  logic [N-1:0] h, acc;
  logic [N*W-1:0] slot_d;
  logic [CW-1:0] skew;
  logic cnt_on, out_free, fire, start;
  assign out_free = !bus.o_z_v | bus.i_z_r;
  assign fire = (&h) & out_free;
  assign bus.o_ax_r = ~h | {N{fire}};
  assign acc = bus.i_ax_v & bus.o_ax_r;
  assign start = (|acc) & (~|h | fire);
  assign bus.o_pend = h;
  // a slot fills on accept and empties on fire unless refilled in the same cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h <= '0;
      slot_d <= '0;
    end else begin
      h <= acc | (h & ~{N{fire}});
      for (int i = 0; i < N; i++)
        if (acc[i]) slot_d[i*W +: W] <= bus.i_ax_d[i*W +: W];
    end
  // skew restarts on the first capture of a set, counts while incomplete, saturates, freezes when full
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      skew <= '0;
      cnt_on <= 1'b0;
    end else if (start) begin
      skew <= '0;
      cnt_on <= 1'b1;
    end else if (fire) cnt_on <= 1'b0;
    else if (cnt_on && !(&h) && !(&skew)) skew <= skew + 1'b1;
  // output register loads on fire, drops valid on drain, keeps data and skew
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.o_z_v <= 1'b0;
      bus.o_z_d <= '0;
      bus.o_z_skew <= '0;
    end else if (fire) begin
      bus.o_z_v <= 1'b1;
      bus.o_z_d <= slot_d;
      bus.o_z_skew <= skew;
    end else if (bus.i_z_r) bus.o_z_v <= 1'b0;
endmodule

// File: tb/tb_cory_join.sv
// tb_cory_join: vector table plus hand sequences for saturation, streaming and mid-run reset
module tb_cory_join;
  localparam int N = 3, W = 8, CW = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  cory_join_if #(.N(N), .W(W), .CW(CW)) bus();
  cory_join #(.N(N), .W(W), .CW(CW)) dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [N-1:0] v;
    logic [N*W-1:0] d;
    logic zr;
    logic [N-1:0] er;
    logic ezv;
    logic [N*W-1:0] ezd;
    logic [CW-1:0] esk;
    logic [N-1:0] ep;
  } vec_t;
  vec_t tbl[$];
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic zr,
                              input logic [N-1:0] er, input logic ezv, input logic [N*W-1:0] ezd,
                              input logic [CW-1:0] esk, input logic [N-1:0] ep);
    vec_t r;
    r = '{v, d, zr, er, ezv, ezd, esk, ep};
    tbl.push_back(r);
  endfunction
  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic zr);
    bus.i_ax_v = v;
    bus.i_ax_d = d;
    bus.i_z_r = zr;
  endtask
  task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic zr);
    drive(v, d, zr);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_c, beats;
    drive('0, '0, 1'b1);
    for (int i = 0; i < 10; i++) add(3'b000, 24'h0, 1, 3'b111, 0, 24'h0, 0, 3'b000);
    add(3'b111, 24'h332211, 1, 3'b111, 0, 24'h0, 0, 3'b000);
    add(3'b000, 24'h0, 1, 3'b111, 0, 24'h0, 0, 3'b111);
    add(3'b000, 24'h0, 1, 3'b111, 1, 24'h332211, 0, 3'b000);
    add(3'b000, 24'h0, 1, 3'b111, 0, 24'h332211, 0, 3'b000);
    add(3'b001, 24'h0000AA, 1, 3'b111, 0, 24'h332211, 0, 3'b000);
    add(3'b000, 24'h0, 1, 3'b110, 0, 24'h332211, 0, 3'b001);
    add(3'b010, 24'h00BB00, 1, 3'b110, 0, 24'h332211, 0, 3'b001);
    add(3'b000, 24'h0, 1, 3'b100, 0, 24'h332211, 0, 3'b011);
    add(3'b000, 24'h0, 1, 3'b100, 0, 24'h332211, 0, 3'b011);
    add(3'b100, 24'hCC0000, 1, 3'b100, 0, 24'h332211, 0, 3'b011);
    add(3'b000, 24'h0, 1, 3'b111, 0, 24'h332211, 0, 3'b111);
    add(3'b000, 24'h0, 1, 3'b111, 1, 24'hCCBBAA, 5, 3'b000);
    add(3'b111, 24'h030201, 1, 3'b111, 0, 24'hCCBBAA, 5, 3'b000);
    add(3'b111, 24'h060504, 0, 3'b111, 0, 24'hCCBBAA, 5, 3'b111);
    for (int i = 0; i < 5; i++) add(3'b111, 24'h090807, 0, 3'b000, 1, 24'h030201, 0, 3'b111);
    add(3'b111, 24'h090807, 1, 3'b111, 1, 24'h030201, 0, 3'b111);
    add(3'b000, 24'h0, 1, 3'b111, 1, 24'h060504, 0, 3'b111);
    add(3'b000, 24'h0, 1, 3'b111, 1, 24'h090807, 0, 3'b000);
    add(3'b000, 24'h0, 1, 3'b111, 0, 24'h090807, 0, 3'b000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].zr);
      @(negedge clk);
      chk($sformatf("row%0d_ax_r", i), 32'(bus.o_ax_r), 32'(tbl[i].er));
      chk($sformatf("row%0d_z_v", i), 32'(bus.o_z_v), 32'(tbl[i].ezv));
      chk($sformatf("row%0d_z_d", i), 32'(bus.o_z_d), 32'(tbl[i].ezd));
      chk($sformatf("row%0d_skew", i), 32'(bus.o_z_skew), 32'(tbl[i].esk));
      chk($sformatf("row%0d_pend", i), 32'(bus.o_pend), 32'(tbl[i].ep));
      @(posedge clk);
      #1;
    end
    cyc(3'b011, 24'h00E2E1, 1'b1);
    repeat (20) cyc(3'b000, 24'h0, 1'b1);
    chk("sat_pend", 32'(bus.o_pend), 32'h3);
    chk("sat_ax_r", 32'(bus.o_ax_r), 32'h4);
    cyc(3'b100, 24'hE30000, 1'b1);
    drive(3'b000, 24'h0, 1'b1);
    @(negedge clk);
    chk("sat_fire_ax_r", 32'(bus.o_ax_r), 32'h7);
    @(posedge clk);
    #1;
    chk("sat_z_v", 32'(bus.o_z_v), 32'h1);
    chk("sat_z_d", 32'(bus.o_z_d), 32'hE3E2E1);
    chk("sat_skew", 32'(bus.o_z_skew), 32'h7);
    cyc(3'b000, 24'h0, 1'b1);
    chk("sat_drain", 32'(bus.o_z_v), 32'h0);
    exp_c = 0;
    beats = 0;
    for (int c = 0; c < 104; c++) begin
      drive(c < 100 ? 3'b111 : 3'b000, {3{8'(c)}}, 1'b1);
      @(negedge clk);
      chk("stream_ax_r", 32'(bus.o_ax_r), 32'h7);
      chk("stream_z_v", 32'(bus.o_z_v), 32'(c >= 2 && c <= 101));
      if (bus.o_z_v) begin
        chk("stream_z_d", 32'(bus.o_z_d), 32'({3{exp_c[7:0]}}));
        exp_c++;
        beats++;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_beats", 32'(beats), 32'd100);
    cyc(3'b011, 24'h00B2B1, 1'b1);
    drive(3'b000, 24'h0, 1'b1);
    @(negedge clk);
    chk("rst_pend_before", 32'(bus.o_pend), 32'h3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pend_async", 32'(bus.o_pend), 32'h0);
    chk("rst_z_v_async", 32'(bus.o_z_v), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(3'b100, 24'hC30000, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_beat", 32'(bus.o_z_v), 32'h0);
      chk("rst_pend_after", 32'(bus.o_pend), 32'h4);
      chk("rst_z_d", 32'(bus.o_z_d), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cory_join.md
Name: cory_join

Overview:
- Companion to the valid/ready fan-out stage in the same stream library.
- Where the fan-out splits one transaction into N lane handshakes, cory_join gathers one beat from each of N independent upstream lanes into a per-lane holding slot.
- When all N slots are full, it emits a single concatenated beat on one downstream valid/ready port, through a registered output stage.
- Also reports per-join lane skew: cycles from first lane captured to last lane captured.

Parameters:
- N, 4, number of input lanes (N >= 1)
- W, 8, data width per lane
- CW, 8, width of the skew counter (saturating)

Ports:
- clk  input  1  clock, all state on posedge
- reset_n  input  1  asynchronous active-low reset
- i_ax_v  input  N  per-lane valid
- i_ax_d  input  N*W  per-lane data; lane i in bits [i*W +: W]
- o_ax_r  output  N  per-lane ready
- o_z_v  output  1  joined beat valid
- o_z_d  output  N*W  joined data; lane i in bits [i*W +: W]
- o_z_skew  output  CW  skew of the beat currently on o_z_d
- i_z_r  input  1  downstream ready
- o_pend  output  N  per-lane slot-full flags (status)

Behaviour:
- Reset (async assert, sync release): all slot-full flags h[i]=0, slot data=0, o_z_v=0, o_z_d=0, o_z_skew=0, skew counter=0, counting flag=0.
- Reset mid-operation discards held slots and any output beat; no partial beat ever appears after reset.
- Slot state per lane is EMPTY (h=0) or FULL (h=1).
- out_free = !o_z_v | i_z_r.
- fire = (&h) & out_free.
- o_ax_r[i] = !h[i] | fire. Combinational path i_z_r -> o_ax_r is allowed and required for full throughput.
- Lane accept (i_ax_v[i] & o_ax_r[i]): slot_d[i] <= i_ax_d[i]; h[i] <= 1.
- fire without accept on lane i: h[i] <= 0.
- fire and accept on the same lane in the same cycle: h[i] stays 1 and holds the new data.
- On fire: o_z_v <= 1, o_z_d <= {slot_d}, o_z_skew <= current skew value.
- Output drain (o_z_v & i_z_r & !fire): o_z_v <= 0. o_z_d is retained, not cleared.
- While o_z_v=1 & i_z_r=0, o_z_d and o_z_skew are held stable.
- Latency: if the last missing lane is accepted at edge k and out_free holds, o_z_v rises after edge k+1.
- Sustained throughput: one joined beat per cycle when all lanes are valid every cycle and i_z_r=1.
- Skew counter:
  - Counting starts at the edge where the first lane of a new set is captured, with the counter loaded to 0.
  - Increments by 1 each following cycle while any h[i]=0. Saturates at 2^CW-1; no wrap.
  - Value is frozen once &h=1.
  - On fire: the value is transferred to o_z_skew.
  - If all lanes are captured on the same edge, skew = 0.
  - If fire coincides with new captures, the counter restarts at 0 for the new set.
- Lanes already FULL stall (o_ax_r=0) until fire. A fast lane can never get two beats ahead of a slow lane.
- o_pend = h.
- N=1 degenerates to a 2-deep pipeline (slot + output register). skew is always 0.
- Input valid must not depend on o_ax_r. Data and valid are sampled only on the handshake.

Test Plan:
- Reset check: after reset_n release with all i_ax_v=0 (N=3, W=8) -> o_z_v=0, o_ax_r=3'b111, o_pend=0, o_z_skew=0 for 10 cycles.
- Simultaneous arrival:
  - Stimulus: N=3, all lanes valid at edge k with d=0x11, 0x22, 0x33, i_z_r=1.
  - Expected: o_z_v=1 after edge k+1 with o_z_d=0x332211 and o_z_skew=0.
  - Expected: one beat only.
- Staggered arrival:
  - Stimulus: lane0 captured at edge k, lane1 at k+2, lane2 at k+5.
  - Expected: o_ax_r[0]=0 during k+1..k+5, o_z_v after edge k+6, o_z_skew=5.
- Backpressure:
  - Stimulus: i_z_r=0 for 6 cycles after the first beat while lanes present a second set.
  - Expected: o_z_d stable; second set held in slots; o_ax_r=0 for those lanes.
  - Expected: on i_z_r=1, the second beat follows the first in the next cycle with no loss or duplication.
- Streaming: all lanes valid every cycle with an incrementing counter on each lane, i_z_r=1 for 100 cycles -> 99+ beats, one per cycle, each beat's lanes carrying equal counter values in order.
- Saturation and reset:
  - Stimulus: CW=3, lane2 withheld 20 cycles after lanes 0 and 1 are captured.
  - Expected: o_z_skew=7.
  - Stimulus: reset_n pulsed while lanes 0 and 1 are held.
  - Expected: o_pend=0 and no output beat is produced.
